// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bundle of the fetch unit's memory, redirect and decode-side signals.
// Ports (seen from the fetch unit, modport master):
//   imem_req/imem_addr out, imem_gnt/imem_rvalid/imem_rdata in  -- instruction memory
//   redirect/redirect_pc in                                     -- branch redirect
//   out_valid/out_instr/out_pc/opcode/func out, out_ready in    -- decode handshake
// The slave modport is the mirror image, used by memory/decode/testbench.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [5:0]        opcode;
    logic [10:0]       func;
    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, opcode, func,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );
    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, opcode, func,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC-driven in-order instruction fetch with a DEPTH-entry FIFO toward decode.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    instr_fetch_unit_if.master: memory req/gnt/rvalid, redirect, decode valid/ready
// Requests are credit-limited so that outstanding + buffered never exceeds DEPTH;
// after a redirect, responses still in flight are drained and dropped.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef enum logic {RUN, DRAIN} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, redir_pc;
    logic [CNT_W-1:0]  outst_q, outst_d, count_q, count_d;
    logic [CNT_W:0]    used;
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem [DEPTH];
    logic              req, acc, rsp, push, pop, out_valid;
    logic [31:0]       head_instr;
    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    always_comb begin
        redir_pc  = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
        used      = {1'b0, outst_q} + {1'b0, count_q};
        // rst_n gating keeps the request low while reset is held
        req       = rst_n && (state_q == RUN) && !bus.redirect && (used < (CNT_W+1)'(DEPTH));
        acc       = req && bus.imem_gnt;
        // a response with nothing outstanding is a protocol error and is ignored
        rsp       = bus.imem_rvalid && (outst_q != '0);
        push      = rsp && (state_q == RUN) && !bus.redirect;
        pop       = out_valid && bus.out_ready && !bus.redirect;
        outst_d   = outst_q + CNT_W'(acc) - CNT_W'(rsp);
        pc_d      = bus.redirect ? redir_pc : acc ? pc_q + ADDR_W'(4) : pc_q;
        resp_pc_d = bus.redirect ? redir_pc : push ? resp_pc_q + ADDR_W'(4) : resp_pc_q;
        count_d   = bus.redirect ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
        wr_d      = bus.redirect ? '0 : push ? nxt(wr_q) : wr_q;
        rd_d      = bus.redirect ? '0 : pop ? nxt(rd_q) : rd_q;
        // stay in (or enter) DRAIN only while stale responses remain in flight
        state_d   = ((outst_d != '0) && (bus.redirect || state_q == DRAIN)) ? DRAIN : RUN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            count_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            count_q   <= count_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
        end
    end
    // storage needs no reset: outputs are masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_q] <= bus.imem_rdata;
            pc_mem[wr_q]    <= resp_pc_q;
        end
    end
    assign out_valid     = (state_q == RUN) && (count_q != '0);
    assign head_instr    = out_valid ? instr_mem[rd_q] : '0;
    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = head_instr;
    assign bus.out_pc    = out_valid ? pc_mem[rd_q] : '0;
    assign bus.opcode    = head_instr[31:26];
    assign bus.func      = head_instr[10:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenario tests for instr_fetch_unit.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    instr_fetch_unit_if #(.ADDR_W(32)) bus ();
    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] tag(input logic [31:0] a);
        return {a[7:2], 15'h2b5d, a[10:0] ^ 11'h6a3};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_inputs();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.out_ready   = 1'b0;
    endtask
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        #1 rst_n = 1'b1;
    endtask
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.out_instr); end
        checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.out_pc); end
        checks++; if (bus.opcode !== 6'h0 || bus.func !== 11'h0) begin errors++; $display("FAIL reset_fields: got %h/%h expected 0/0", bus.opcode, bus.func); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req: got %b@%h expected 1@0", bus.imem_req, bus.imem_addr); end
        tick();
    endtask
    task automatic test_streaming();
        logic        pend;
        logic [31:0] pend_addr, e;
        int          n_req, n_out;
        do_reset();
        pend = 1'b0; pend_addr = 32'h0; n_req = 0; n_out = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 60 && n_out < 10; c++) begin
            bus.imem_gnt    = 1'b1;
            bus.imem_rvalid = pend;
            bus.imem_rdata  = pend ? tag(pend_addr) : 32'h0;
            #1;
            if (bus.out_valid) begin
                e = 32'(n_out * 4);
                checks++; if (bus.out_pc !== e) begin errors++; $display("FAIL stream_pc: got %h expected %h", bus.out_pc, e); end
                checks++; if (bus.out_instr !== tag(e)) begin errors++; $display("FAIL stream_instr: got %h expected %h", bus.out_instr, tag(e)); end
                checks++; if (bus.opcode !== e[7:2]) begin errors++; $display("FAIL stream_opcode: got %h expected %h", bus.opcode, e[7:2]); end
                checks++; if (bus.func !== (e[10:0] ^ 11'h6a3)) begin errors++; $display("FAIL stream_func: got %h expected %h", bus.func, e[10:0] ^ 11'h6a3); end
                n_out++;
            end
            pend = bus.imem_req;
            if (bus.imem_req) begin
                checks++; if (bus.imem_addr !== 32'(n_req * 4)) begin errors++; $display("FAIL stream_addr: got %h expected %h", bus.imem_addr, 32'(n_req * 4)); end
                pend_addr = bus.imem_addr;
                n_req++;
            end
            tick();
        end
        checks++; if (n_out != 10) begin errors++; $display("FAIL stream_count: got %0d expected 10", n_out); end
        idle_inputs();
    endtask
    task automatic test_backpressure();
        logic        pend, found;
        logic [31:0] pend_addr;
        int          n_req;
        do_reset();
        pend = 1'b0; pend_addr = 32'h0; n_req = 0; found = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.imem_gnt    = 1'b1;
            bus.imem_rvalid = pend;
            bus.imem_rdata  = pend ? tag(pend_addr) : 32'h0;
            #1;
            if (bus.imem_req) n_req++;
            pend = bus.imem_req;
            pend_addr = bus.imem_addr;
            if (c >= 3) begin
                checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %b expected 0", bus.imem_req); end
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", bus.out_valid); end
                checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== tag(32'h0)) begin errors++; $display("FAIL bp_head_stable: got %h/%h expected 0/%h", bus.out_pc, bus.out_instr, tag(32'h0)); end
            end
            tick();
        end
        checks++; if (n_req != 2) begin errors++; $display("FAIL bp_req_count: got %0d expected 2", n_req); end
        bus.imem_rvalid = 1'b0;
        bus.out_ready   = 1'b1;
        for (int c = 0; c < 6 && !found; c++) begin
            #1;
            if (bus.imem_req) begin
                found = 1'b1;
                checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL bp_resume_addr: got %h expected 8", bus.imem_addr); end
                checks++; if (bus.out_pc !== 32'h4) begin errors++; $display("FAIL bp_resume_head: got %h expected 4", bus.out_pc); end
            end
            tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL bp_resume_timeout: got no request expected one within 6 cycles"); end
        idle_inputs();
    endtask
    task automatic test_redirect_inflight();
        do_reset();
        bus.out_ready = 1'b1;
        bus.imem_gnt  = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rd_req0: got %b@%h expected 1@0", bus.imem_req, bus.imem_addr); end
        tick();
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL rd_req1: got %b@%h expected 1@4", bus.imem_req, bus.imem_addr); end
        tick();
        bus.redirect = 1'b1; bus.redirect_pc = 32'h42;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rd_req_redirect: got %b expected 0", bus.imem_req); end
        tick();
        bus.redirect = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hdead0001;
        #1;
        checks++; if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rd_drain1: got req=%b valid=%b expected 0/0", bus.imem_req, bus.out_valid); end
        tick();
        bus.imem_rdata = 32'hdead0002;
        #1;
        checks++; if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rd_drain2: got req=%b valid=%b expected 0/0", bus.imem_req, bus.out_valid); end
        tick();
        bus.imem_rvalid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rd_dropped: got %b expected 0", bus.out_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin errors++; $display("FAIL rd_restart: got %b@%h expected 1@40", bus.imem_req, bus.imem_addr); end
        tick();
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = tag(32'h40);
        #1;
        checks++; if (bus.imem_addr !== 32'h44) begin errors++; $display("FAIL rd_next_addr: got %h expected 44", bus.imem_addr); end
        tick();
        bus.imem_rvalid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_instr !== tag(32'h40)) begin errors++; $display("FAIL rd_first_out: got %b %h %h expected 1 40 %h", bus.out_valid, bus.out_pc, bus.out_instr, tag(32'h40)); end
        tick();
        idle_inputs();
    endtask
    task automatic test_redirect_collide();
        do_reset();
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = tag(32'h0);
        tick();
        bus.imem_rdata = tag(32'h4); bus.out_ready = 1'b1;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h80;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL col_pre: got valid=%b req=%b expected 1/0", bus.out_valid, bus.imem_req); end
        tick();
        bus.redirect = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_gnt = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL col_flushed: got %b expected 0", bus.out_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin errors++; $display("FAIL col_restart: got %b@%h expected 1@80", bus.imem_req, bus.imem_addr); end
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = tag(32'h80);
        tick();
        bus.imem_rvalid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h80) begin errors++; $display("FAIL col_out: got %b@%h expected 1@80", bus.out_valid, bus.out_pc); end
        tick();
        idle_inputs();
    endtask
    task automatic test_grant_stall();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL stall_hold: got %b@%h expected 1@0", bus.imem_req, bus.imem_addr); end
            tick();
        end
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL stall_after_gnt: got %b@%h expected 1@4", bus.imem_req, bus.imem_addr); end
            tick();
        end
        idle_inputs();
    endtask
    task automatic test_pc_wrap();
        do_reset();
        bus.redirect = 1'b1; bus.redirect_pc = 32'hffff_ffff; bus.imem_gnt = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL wrap_redirect_req: got %b expected 0", bus.imem_req); end
        tick();
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 32'hffff_fffc) begin errors++; $display("FAIL wrap_aligned: got %h expected fffffffc", bus.imem_addr); end
        tick();
        bus.imem_gnt = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h expected 0", bus.imem_addr); end
        tick();
        idle_inputs();
    endtask
    task automatic test_async_reset();
        do_reset();
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = tag(32'h0);
        tick();
        bus.imem_gnt = 1'b0; bus.imem_rdata = tag(32'h4);
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b expected 1", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL ar_immediate: got valid=%b req=%b expected 0/0", bus.out_valid, bus.imem_req); end
        checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin errors++; $display("FAIL ar_outputs: got %h/%h expected 0/0", bus.out_pc, bus.out_instr); end
        bus.imem_rvalid = 1'b0;
        tick();
        tick();
        #1 rst_n = 1'b1;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0bad0bad;
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL ar_restart: got %b@%h expected 1@0", bus.imem_req, bus.imem_addr); end
        tick();
        bus.imem_rvalid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL ar_stray_ignored: got valid=%b addr=%h expected 0/0", bus.out_valid, bus.imem_addr); end
        tick();
        idle_inputs();
    endtask
    initial begin
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collide();
        test_grant_stall();
        test_pc_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
